// File: rtl/test_result_collector.sv
// Result collector for a set of test_* benches: sequences their shared reset, latches
// per-bench fail/finish flags and raises a registered done/pass verdict with a RUN timeout.
// Optional `COLLECTOR_DISPLAY_EN adds simulation-only progress and verdict messages.
module test_result_collector #(
  parameter int NUM_TESTS  = 8,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_TESTS-1:0]           test_fail,
  input  logic [NUM_TESTS-1:0]           test_finish,
  output logic                           test_reset,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [NUM_TESTS-1:0]           fail_mask,
  output logic [NUM_TESTS-1:0]           finish_mask,
  output logic [$clog2(NUM_TESTS+1)-1:0] fail_count,
  output logic [$clog2(NUM_TESTS+1)-1:0] finish_count
);

  localparam int CW   = $clog2(NUM_TESTS + 1);
  localparam int CMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : (RST_CYCLES + 1);
  localparam int CTW  = $clog2(CMAX);
  localparam logic [CTW-1:0] CNT_ZERO    = {CTW{1'b0}};
  localparam logic [CTW-1:0] CNT_ONE     = CTW'(1);
  localparam logic [CTW-1:0] CNT_RST_END = CTW'(RST_CYCLES - 1);
  localparam logic [CTW-1:0] CNT_TO_END  = CTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RST  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [CW-1:0] popcount(input logic [NUM_TESTS-1:0] m);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int i = 0; i < NUM_TESTS; i++) begin
      c = c + CW'(m[i]);
    end
    return c;
  endfunction

  state_t               state_r, state_s;
  logic [CTW-1:0]       cnt_r, cnt_s;
  logic                 test_reset_r, test_reset_s;
  logic                 done_r, done_s;
  logic                 pass_r, pass_s;
  logic                 timeout_r, timeout_s;
  logic [NUM_TESTS-1:0] fail_mask_r, fail_mask_s;
  logic [NUM_TESTS-1:0] finish_mask_r, finish_mask_s;
  logic [CW-1:0]        fail_count_r, fail_count_s;
  logic [CW-1:0]        finish_count_r, finish_count_s;
  logic [NUM_TESTS-1:0] fail_in_s, finish_in_s;

  // Benches leave their flags unreset, so anything other than a clean 1 reads as 0.
  always_comb begin
    fail_in_s   = {NUM_TESTS{1'b0}};
    finish_in_s = {NUM_TESTS{1'b0}};
    for (int i = 0; i < NUM_TESTS; i++) begin
      fail_in_s[i]   = (test_fail[i] === 1'b1);
      finish_in_s[i] = (test_finish[i] === 1'b1);
    end
  end

  // Next-state, mask and verdict logic.
  always_comb begin
    state_s        = state_r;
    cnt_s          = cnt_r;
    test_reset_s   = test_reset_r;
    done_s         = done_r;
    pass_s         = pass_r;
    timeout_s      = timeout_r;
    fail_mask_s    = fail_mask_r;
    finish_mask_s  = finish_mask_r;
    case (state_r)
      ST_INIT: begin
        state_s      = ST_RST;
        cnt_s        = CNT_ZERO;
        test_reset_s = 1'b1;
      end
      ST_RST: begin
        if (cnt_r == CNT_RST_END) begin
          state_s      = ST_RUN;
          cnt_s        = CNT_ZERO;
          test_reset_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        // A finished bench is frozen: its later fail/finish activity is masked off.
        fail_mask_s   = fail_mask_r | (fail_in_s & ~finish_mask_r);
        finish_mask_s = finish_mask_r | finish_in_s;
        if (&finish_mask_s) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          pass_s  = (fail_mask_s == {NUM_TESTS{1'b0}});
        end else if (cnt_r == CNT_TO_END) begin
          state_s   = ST_DONE;
          done_s    = 1'b1;
          timeout_s = 1'b1;
          pass_s    = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
    fail_count_s   = popcount(fail_mask_s);
    finish_count_s = popcount(finish_mask_s);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r        <= ST_INIT;
      cnt_r          <= CNT_ZERO;
      test_reset_r   <= 1'b1;
      done_r         <= 1'b0;
      pass_r         <= 1'b0;
      timeout_r      <= 1'b0;
      fail_mask_r    <= {NUM_TESTS{1'b0}};
      finish_mask_r  <= {NUM_TESTS{1'b0}};
      fail_count_r   <= {CW{1'b0}};
      finish_count_r <= {CW{1'b0}};
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      test_reset_r   <= test_reset_s;
      done_r         <= done_s;
      pass_r         <= pass_s;
      timeout_r      <= timeout_s;
      fail_mask_r    <= fail_mask_s;
      finish_mask_r  <= finish_mask_s;
      fail_count_r   <= fail_count_s;
      finish_count_r <= finish_count_s;
    end
  end

  assign test_reset   = test_reset_r;
  assign done         = done_r;
  assign pass         = pass_r;
  assign timeout      = timeout_r;
  assign fail_mask    = fail_mask_r;
  assign finish_mask  = finish_mask_r;
  assign fail_count   = fail_count_r;
  assign finish_count = finish_count_r;

`ifdef COLLECTOR_DISPLAY_EN
  // Progress trace: one line per newly finished bench, then the verdict on DONE entry.
  always @(posedge clock) begin
    if (reset_n && (state_r == ST_RUN)) begin
      for (int i = 0; i < NUM_TESTS; i++) begin
        if (finish_mask_s[i] && !finish_mask_r[i]) begin
          $display("[test_result_collector] test %0d %s", i, fail_mask_s[i] ? "FAIL" : "PASS");
        end
      end
      if (state_s == ST_DONE) begin
        $display("[test_result_collector] finished=%0d failed=%0d timeout=%0d",
                 finish_count_s, fail_count_s, timeout_s);
        if (!pass_s) begin
          $display("~~FAIL~~");
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_test_result_collector.sv
// Scoreboard bench for test_result_collector: stimulus queues time-stamped output
// snapshots, a negedge monitor pops and compares one on every output change.
module tb_test_result_collector;

  localparam int NT = 4;
  localparam int RC = 4;
  localparam int TO = 16;

  typedef struct packed {
    logic       tr;
    logic       d;
    logic       p;
    logic       t;
    logic [3:0] fm;
    logic [3:0] fim;
    logic [2:0] fc;
    logic [2:0] fic;
  } snap_t;

  typedef struct {
    int    stamp;
    snap_t s;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NT-1:0] test_fail;
  logic [NT-1:0] test_finish;
  logic          test_reset;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [NT-1:0] fail_mask;
  logic [NT-1:0] finish_mask;
  logic [2:0]    fail_count;
  logic [2:0]    finish_count;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   first = 1'b1;
  bit   end_chk = 1'b0;
  bit   end_done = 1'b0;
  snap_t prev;
  exp_t  exp_q[$];

  test_result_collector #(.NUM_TESTS(NT), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .test_fail(test_fail), .test_finish(test_finish),
    .test_reset(test_reset), .done(done), .pass(pass), .timeout(timeout),
    .fail_mask(fail_mask), .finish_mask(finish_mask),
    .fail_count(fail_count), .finish_count(finish_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic snap_t mk(bit tr, bit d, bit p, bit t, logic [3:0] fm, logic [3:0] fim);
    snap_t s;
    s.tr  = tr;
    s.d   = d;
    s.p   = p;
    s.t   = t;
    s.fm  = fm;
    s.fim = fim;
    s.fc  = 3'($countones(fm));
    s.fic = 3'($countones(fim));
    return s;
  endfunction

  task automatic push(input int stamp, input snap_t s);
    exp_t e;
    e.stamp = stamp;
    e.s     = s;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset and sequence into RUN; run0 is the stamp at which test_reset falls.
  task automatic start(input bit clear, input bit dirty, output int run0);
    reset_n     = 1'b0;
    test_fail   = dirty ? 4'bxxxx : 4'b0000;
    test_finish = dirty ? 4'bxxxx : 4'b0000;
    if (clear) push(cyc + 1, mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
    step();
    step();
    reset_n = 1'b1;
    run0 = cyc + RC + 1;
    push(run0, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
    if (dirty) begin
      test_fail   = 4'b1111;
      test_finish = 4'b1111;
    end
    while (cyc < run0) step();
    test_fail   = 4'b0000;
    test_finish = 4'b0000;
  endtask

  // One-cycle pulse sampled on RUN edge k.
  task automatic pulse(input int run0, input int k, input logic [3:0] f, input logic [3:0] fi);
    while (cyc < run0 + k - 1) step();
    test_fail   = f;
    test_finish = fi;
    step();
    test_fail   = 4'b0000;
    test_finish = 4'b0000;
  endtask

  always @(negedge clock) begin
    snap_t cur;
    exp_t  e;
    cur = {test_reset, done, pass, timeout, fail_mask, finish_mask, fail_count, finish_count};
    if (mon_en && (first || (cur !== prev))) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: stamp=%0d got=%h, no event was expected", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if ((e.stamp != cyc) || (e.s !== cur)) begin
          failures++;
          $display("FAIL event: got stamp=%0d snap=%h, expected stamp=%0d snap=%h",
                   cyc, cur, e.stamp, e.s);
        end
      end
      first = 1'b0;
      prev  = cur;
    end
    if (end_chk && !end_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL missing_events: %0d left, expected 0; next stamp=%0d",
                 exp_q.size(), exp_q[0].stamp);
      end
      end_done = 1'b1;
    end
  end

  initial begin
    int r0;
    reset_n     = 1'b0;
    test_fail   = 4'b0000;
    test_finish = 4'b0000;
    repeat (3) step();
    push(cyc, mk(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
    mon_en = 1'b1;

    // Clean finishes at RUN cycles 1,2,3,5.
    start(1'b0, 1'b0, r0);
    push(r0 + 1, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001));
    push(r0 + 2, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011));
    push(r0 + 3, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0111));
    push(r0 + 5, mk(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111));
    pulse(r0, 1, 4'b0000, 4'b0001);
    pulse(r0, 2, 4'b0000, 4'b0010);
    pulse(r0, 3, 4'b0000, 4'b0100);
    pulse(r0, 5, 4'b0000, 4'b1000);

    // Bench 2 fails and finishes together.
    start(1'b1, 1'b0, r0);
    push(r0 + 1, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001));
    push(r0 + 2, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011));
    push(r0 + 3, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0111));
    push(r0 + 4, mk(1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b1111));
    pulse(r0, 1, 4'b0000, 4'b0001);
    pulse(r0, 2, 4'b0000, 4'b0010);
    pulse(r0, 3, 4'b0100, 4'b0100);
    pulse(r0, 4, 4'b0000, 4'b1000);

    // Bench 1 fails after it already finished: ignored.
    start(1'b1, 1'b0, r0);
    push(r0 + 1,  mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001));
    push(r0 + 2,  mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0101));
    push(r0 + 4,  mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0111));
    push(r0 + 12, mk(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111));
    pulse(r0, 1,  4'b0000, 4'b0001);
    pulse(r0, 2,  4'b0000, 4'b0100);
    pulse(r0, 4,  4'b0000, 4'b0010);
    pulse(r0, 10, 4'b0010, 4'b0000);
    pulse(r0, 12, 4'b0000, 4'b1000);

    // Bench 3 never finishes in budget; a late finish after DONE is ignored.
    start(1'b1, 1'b0, r0);
    push(r0 + 1,  mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001));
    push(r0 + 2,  mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011));
    push(r0 + 3,  mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0111));
    push(r0 + 16, mk(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0111));
    pulse(r0, 1,  4'b0000, 4'b0001);
    pulse(r0, 2,  4'b0000, 4'b0010);
    pulse(r0, 3,  4'b0000, 4'b0100);
    pulse(r0, 18, 4'b1000, 4'b1000);

    // X then all-ones before RUN, then all benches finish at cycle 2.
    start(1'b1, 1'b1, r0);
    push(r0 + 2, mk(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111));
    pulse(r0, 2, 4'b0000, 4'b1111);

    // Reset mid-RUN with two finishes latched, then a full clean rerun.
    start(1'b1, 1'b0, r0);
    push(r0 + 1, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001));
    push(r0 + 2, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011));
    pulse(r0, 1, 4'b0000, 4'b0001);
    pulse(r0, 2, 4'b0000, 4'b0010);
    start(1'b1, 1'b0, r0);
    push(r0 + 1, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001));
    push(r0 + 2, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011));
    push(r0 + 3, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0111));
    push(r0 + 5, mk(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111));
    pulse(r0, 1, 4'b0000, 4'b0001);
    pulse(r0, 2, 4'b0000, 4'b0010);
    pulse(r0, 3, 4'b0000, 4'b0100);
    pulse(r0, 5, 4'b0000, 4'b1000);

    // Last finish on the final budget cycle: completion beats timeout.
    start(1'b1, 1'b0, r0);
    push(r0 + 1,  mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0111));
    push(r0 + 16, mk(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111));
    pulse(r0, 1,  4'b0000, 4'b0111);
    pulse(r0, 16, 4'b0000, 4'b1000);

    repeat (5) step();
    end_chk = 1'b1;
    repeat (3) step();
    if (!end_done) begin
      $display("FAIL end_check: monitor never ran the final check");
      $fatal(1, "end check not reached");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
